// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_shift_add_mult_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // The counter must represent 0..width inclusive.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negation, used both for operand magnitudes and for the signed result.
module mult_sign_fix #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is exact when the result is read as unsigned.
   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: signed operands are reduced to magnitudes,
// multiplied in WIDTH shift-add steps, and the result sign is fixed up on entry to DONE.
module seq_shift_add_mult
   import seq_shift_add_mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter bit          SIGNED_SUPPORT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic                 eff_signed;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   fixed_product;
   logic [WIDTH:0]       step_sum;

   assign eff_signed = signed_mode & SIGNED_SUPPORT;

   mult_sign_fix #(
      .WIDTH (WIDTH)
   ) u_fix_a (
      .value  (a),
      .negate (eff_signed & a[WIDTH-1]),
      .result (mag_a)
   );

   mult_sign_fix #(
      .WIDTH (WIDTH)
   ) u_fix_b (
      .value  (b),
      .negate (eff_signed & b[WIDTH-1]),
      .result (mag_b)
   );

   mult_sign_fix #(
      .WIDTH (2 * WIDTH)
   ) u_fix_result (
      .value  ({acc_q, mplier_q}),
      .negate (neg_q),
      .result (fixed_product)
   );

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      // Carry out of the add lands in the top bit and is shifted back into acc.
      step_sum  = mplier_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = mag_a;
               mplier_d = mag_b;
               acc_d    = '0;
               cnt_d    = '0;
               neg_d    = eff_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               state_d  = StRun;
            end
         end
         StRun: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               product_d = fixed_product;
               state_d   = StDone;
            end else begin
               acc_d    = step_sum[WIDTH:1];
               mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign product   = product_q;

endmodule
